// File: rtl/apb_mem_ctrl.sv
// APB slave bridging single-beat transfers onto a simple strobed memory port,
// with configurable wait states and sticky error reporting.
module apb_mem_ctrl #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 64,
  parameter int                MEM_SIZE    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 1,
  localparam int               SW          = DATA_W / 8,
  localparam int               BW          = $clog2(SW),
  localparam int               AW          = MEM_SIZE - BW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [DATA_W-1:0] pwdata_i,
  input  logic [SW-1:0]     pstrb_i,
  output logic [DATA_W-1:0] prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [SW-1:0]     mem_wstrb_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [2:0]        err_flags_o,
  output logic [15:0]       err_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_MEM, S_RESP} state_e;

  // Bounds are one bit wider than the address so BASE_ADDR + size cannot wrap.
  localparam logic [ADDR_W:0] MEM_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] MEM_HI = MEM_LO + ((ADDR_W + 1)'(1) << MEM_SIZE);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SW-1:0]     strb_q;
  logic [AW-1:0]     word_q;
  logic [2:0]        cause_q;
  logic [2:0]        err_flags_q;
  logic [15:0]       err_cnt_q;

  logic out_of_range, misaligned, changed, mem_go, resp;

  assign out_of_range = ({1'b0, paddr_i} < MEM_LO) || ({1'b0, paddr_i} >= MEM_HI);
  assign misaligned   = |paddr_i[BW-1:0];
  assign changed      = (paddr_i != addr_q) || (pwrite_i != write_q) ||
                        (pwdata_i != wdata_q) || (pstrb_i != strb_q);

  // Strobe and response depend on the live bus so a same-cycle protocol
  // violation, deselect or reset still suppresses them.
  assign mem_go    = !rst_i && psel_i && (state_q == S_MEM) && (cause_q == 3'b000) && !changed;
  assign mem_we_o  = mem_go && write_q;
  assign mem_re_o  = mem_go && !write_q;
  assign resp      = !rst_i && psel_i && (state_q == S_RESP);
  assign pready_o  = resp;
  assign pslverr_o = resp && (cause_q != 3'b000);
  assign prdata_o  = (resp && !write_q && (cause_q == 3'b000)) ? mem_rdata_i : '0;

  assign mem_addr_o  = word_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wstrb_o = strb_q;
  assign err_flags_o = err_flags_q;
  assign err_cnt_o   = err_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      word_q      <= '0;
      cause_q     <= '0;
      err_flags_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (psel_i && !penable_i) begin
            write_q <= pwrite_i;
            addr_q  <= paddr_i;
            wdata_q <= pwdata_i;
            strb_q  <= pstrb_i;
            word_q  <= AW'((paddr_i - BASE_ADDR) >> BW);
            cause_q <= {1'b0, misaligned, out_of_range};
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= (WAIT_CYCLES > 0) ? S_WAIT : S_MEM;
          end
        end
        S_WAIT: begin
          if (!psel_i) begin
            state_q <= S_IDLE;
          end else begin
            if (changed) cause_q[2] <= 1'b1;
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_q <= S_MEM;
          end
        end
        S_MEM: begin
          if (!psel_i) begin
            state_q <= S_IDLE;
          end else begin
            if (changed) cause_q[2] <= 1'b1;
            state_q <= S_RESP;
          end
        end
        default: begin
          state_q <= S_IDLE;
          if (psel_i && (cause_q != 3'b000)) begin
            err_flags_q <= cause_q;
            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/apb_mem_ctrl.md
APB_MEM_CTRL -- requirements
Module: apb_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 64, data width; legal values are 32 and 64.
REQ-003 SHALL have parameter MEM_SIZE, default 16, log2 of the memory size in bytes.
REQ-004 SHALL have parameter BASE_ADDR, default 0, first byte address of the memory.
REQ-005 SHALL have parameter WAIT_CYCLES, default 1, wait states inserted before the memory strobe (0..15).
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 Ports (clock and reset first):
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous active-high reset.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  1 = write, 0 = read.
- paddr_i  in  ADDR_W  byte address.
- pwdata_i  in  DATA_W  write data.
- pstrb_i  in  DATA_W/8  byte strobes.
- prdata_o  out  DATA_W  read data.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  error response; valid only while pready_o=1.
- mem_we_o  out  1  single-cycle write strobe.
- mem_re_o  out  1  single-cycle read strobe.
- mem_addr_o  out  AW  word index, where AW = MEM_SIZE - log2(DATA_W/8).
- mem_wdata_o  out  DATA_W  write data.
- mem_wstrb_o  out  DATA_W/8  byte enables.
- mem_rdata_i  in  DATA_W  read data, valid 1 cycle after mem_re_o.
- err_flags_o  out  3  sticky error cause from the last errored transfer.
- err_cnt_o  out  16  saturating count of errored transfers.

Function
REQ-008 The FSM SHALL have the states IDLE, WAIT, MEM and RESP.
REQ-009 In IDLE, psel_i=1 with penable_i=0 (setup cycle) SHALL capture pwrite, paddr, pwdata and pstrb, compute the error cause, load the wait counter with WAIT_CYCLES, and go to WAIT if WAIT_CYCLES>0, else to MEM.
REQ-010 In IDLE, psel_i=1 with penable_i=1 SHALL be ignored: no capture and no pready_o.
REQ-011 The out-of-range cause SHALL be paddr < BASE_ADDR or paddr >= BASE_ADDR + 2**MEM_SIZE, compared at ADDR_W+1 bits so that the bound cannot overflow.
REQ-012 The misaligned cause SHALL be paddr[log2(DATA_W/8)-1:0] != 0.
REQ-013 The protocol cause SHALL be any change of paddr_i, pwrite_i, pwdata_i or pstrb_i relative to the captured values in any WAIT or MEM cycle.
REQ-014 WAIT SHALL decrement the counter each cycle and go to MEM in the cycle the counter reaches 1.
REQ-015 MEM SHALL last exactly 1 cycle, then go to RESP.
REQ-016 In MEM, if no cause is set (including a protocol check in that same cycle), the block SHALL assert mem_we_o (write) or mem_re_o (read) for 1 cycle.
REQ-017 mem_addr_o SHALL equal (paddr - BASE_ADDR) >> log2(DATA_W/8); mem_wdata_o and mem_wstrb_o SHALL be the captured values.
REQ-018 In MEM, if any cause is set, no strobe SHALL be issued.
REQ-019 RESP SHALL assert pready_o for exactly 1 cycle, then go to IDLE; pslverr_o=1 if any cause is set.
REQ-020 On a read with no error, prdata_o SHALL equal mem_rdata_i sampled in the RESP cycle.
REQ-021 On a write or an errored transfer, prdata_o SHALL be 0.
REQ-022 Latency: pready_o SHALL assert exactly WAIT_CYCLES+2 cycles after the setup cycle, for both error and non-error transfers.
REQ-023 Outside RESP, pready_o, pslverr_o and prdata_o SHALL be 0.
REQ-024 If psel_i=0 in WAIT, MEM or RESP, the block SHALL return to IDLE next cycle: no strobe, no response, no counter update.
REQ-025 If psel_i=0 in the MEM cycle itself, the strobe SHALL be suppressed.
REQ-026 In RESP with pslverr_o=1, err_flags_o SHALL load {protocol, misaligned, out_of_range}.
REQ-027 In RESP with pslverr_o=1, err_cnt_o SHALL increment and saturate at 16'hFFFF.
REQ-028 err_flags_o and err_cnt_o SHALL hold their values otherwise.
REQ-029 A new setup cycle in the cycle right after RESP SHALL be accepted (back-to-back transfers).

Reset
REQ-030 On rst_i=1 at a rising edge, the state SHALL become IDLE and all outputs SHALL become 0, including err_flags_o and err_cnt_o.
REQ-031 Reset mid-transfer SHALL abort it with no strobe; rst_i SHALL take priority over every other input.

Verification
REQ-032 (WAIT_CYCLES=1, DATA_W=64) Write to 0x10 with pstrb 0xFF, data 0xA5 -> mem_we_o=1 with mem_addr_o=2 at cycle 2; pready_o=1, pslverr_o=0 at cycle 3.
REQ-033 Read from 0x10 with mem_rdata_i=0xDEAD in the RESP cycle -> mem_re_o=1 at cycle 2; prdata_o=0xDEAD with pready_o=1 at cycle 3.
REQ-034 Access at 0x10004 with MEM_SIZE=16 -> no strobe; pslverr_o=1 at cycle 3; err_flags_o=3'b011; err_cnt_o=1.
REQ-035 Write to 0x08 with paddr changed to 0x18 in the WAIT cycle -> no mem_we_o; pslverr_o=1; err_flags_o=3'b100.
REQ-036 psel_i dropped in WAIT, then rst_i pulsed while in MEM -> no strobe and no pready_o in either case; all outputs 0 after reset.
REQ-037 err_cnt_o preloaded to 0xFFFF via 65535 errored transfers, then 1 more error -> err_cnt_o stays 0xFFFF.
